ex_tracker: RTL and testbench

- Parametrised successor to the single-issue execute-entry manager.
- Holds one IS_EX_PACKET per RS slot while the instruction executes.
- Models per-entry functional-unit latency with a countdown; accepts up to N_ISSUE issues per cycle.
- Drains finished entries to N_WB writeback ports with a valid/ready handshake; sits between issue (RS) and complete/CDB.

---
 rtl/ex_tracker_pkg.sv | 43 ++++
 rtl/ex_tracker_if.sv | 21 ++
 rtl/ex_wb_select.sv | 42 ++++
 rtl/ex_tracker.sv | 151 +++++++++++++++
 tb/tb_ex_tracker.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_tracker_pkg.sv
// ----------------------------------------------------------------------------
// ex_tracker_pkg
//   Shared types for the execute-stage entry tracker and its drain logic.
//   - IS_EX_PACKET   : issue->execute packet carried by each RS slot
//   - EX_TRACK_ENTRY : tracker slot = packet + remaining-latency counter
//   - NOP_INST       : instruction word used for empty slots (`NOP)
//   - LAT_W_DEF      : default latency counter width
// ----------------------------------------------------------------------------
`ifndef RS_SZ
`define RS_SZ 8
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif

package ex_tracker_pkg;

    localparam int RS_SZ     = `RS_SZ;
    localparam int RS_IDX_W  = (RS_SZ > 1) ? $clog2(RS_SZ) : 1;
    localparam int LAT_W_DEF = 4;
    localparam logic [31:0] NOP_INST = `NOP;

    typedef struct packed {
        logic [31:0]         inst;
        logic [31:0]         npc;
        logic [RS_IDX_W-1:0] rs_idx;
        logic                valid;
    } IS_EX_PACKET;

    typedef struct packed {
        IS_EX_PACKET          pkt;
        logic [LAT_W_DEF-1:0] cnt;
    } EX_TRACK_ENTRY;

    // Empty slot: NOP instruction, not valid, NPC and counter zero.
    function automatic EX_TRACK_ENTRY empty_entry();
        EX_TRACK_ENTRY e;
        e          = '0;
        e.pkt.inst = NOP_INST;
        return e;
    endfunction

endpackage

// File: rtl/ex_tracker_if.sv
// ----------------------------------------------------------------------------
// ex_tracker_if
//   Writeback handshake bundle between the tracker and complete/CDB.
//   master : tracker side   (drives wb_valid, wb_packet, wb_idx; reads wb_ready)
//   slave  : consumer side  (reads the above; drives wb_ready)
// ----------------------------------------------------------------------------
interface ex_tracker_if import ex_tracker_pkg::*; #(
    parameter  int DEPTH = RS_SZ,
    parameter  int N_WB  = 2,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) ();

    logic [N_WB-1:0]  wb_valid;
    IS_EX_PACKET      wb_packet [N_WB];
    logic [IDX_W-1:0] wb_idx    [N_WB];
    logic [N_WB-1:0]  wb_ready;

    modport master (output wb_valid, output wb_packet, output wb_idx, input  wb_ready);
    modport slave  (input  wb_valid, input  wb_packet, input  wb_idx, output wb_ready);

endinterface

// File: rtl/ex_wb_select.sv
// ----------------------------------------------------------------------------
// ex_wb_select
//   N_WB-way lowest-index picker: port p is granted the (p+1)-th lowest set
//   bit of the request vector. Purely combinational.
//   i_req   : DEPTH-bit request vector
//   o_valid : per-port grant valid
//   o_grant : per-port one-hot grant (all zero when not valid)
//   o_idx   : per-port encoded index (zero when not valid)
// ----------------------------------------------------------------------------
module ex_wb_select #(
    parameter  int DEPTH = 8,
    parameter  int N_WB  = 2,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0] i_req,
    output logic [N_WB-1:0]  o_valid,
    output logic [DEPTH-1:0] o_grant [N_WB],
    output logic [IDX_W-1:0] o_idx   [N_WB]
);

    always_comb begin
        logic [DEPTH-1:0] remaining;
        // NOTE: every output gets a default before the loops so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        remaining = i_req;
        for (int p = 0; p < N_WB; p++) begin
            o_valid[p] = 1'b0;
            o_grant[p] = '0;
            o_idx[p]   = '0;
            for (int s = 0; s < DEPTH; s++) begin
                if (remaining[s] && !o_valid[p]) begin
                    o_valid[p]    = 1'b1;
                    o_grant[p][s] = 1'b1;
                    o_idx[p]      = IDX_W'(s);
                end
            end
            // Later ports search only what earlier ports did not take.
            remaining = remaining & ~o_grant[p];
        end
    end

endmodule

// File: rtl/ex_tracker.sv
// ----------------------------------------------------------------------------
// ex_tracker
//   Execute-entry tracker: one IS_EX_PACKET per RS slot with a countdown of
//   remaining execute cycles; finished slots drain through N_WB writeback
//   ports using a valid/ready handshake.
//   i_clock, i_reset(async, active low), i_interrupt(sync flush)
//   i_is_ex_packet/i_issue_lat : N_ISSUE issue ports
//   wb                         : writeback handshake (ex_tracker_if.master)
//   o_ex_entries, o_ex_busy, o_ex_count, o_collision : state visibility
//   Optional (EX_TRACKER_PERF_EN): o_ex_hiwater, o_wb_stall_cycles
//   LAT_W must equal LAT_W_DEF since the entry struct lives in the package.
// ----------------------------------------------------------------------------
module ex_tracker import ex_tracker_pkg::*; #(
    parameter  int DEPTH   = RS_SZ,
    parameter  int N_ISSUE = 2,
    parameter  int N_WB    = 2,
    parameter  int LAT_W   = LAT_W_DEF,
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_interrupt,
    input  IS_EX_PACKET      i_is_ex_packet [N_ISSUE],
    input  logic [LAT_W-1:0] i_issue_lat    [N_ISSUE],
    ex_tracker_if.master     wb,
    output IS_EX_PACKET      o_ex_entries   [DEPTH],
    output logic [DEPTH-1:0] o_ex_busy,
    output logic [CNT_W-1:0] o_ex_count,
    output logic             o_collision
`ifdef EX_TRACKER_PERF_EN
    ,
    output logic [CNT_W-1:0] o_ex_hiwater,
    output logic [31:0]      o_wb_stall_cycles
`endif
);

    EX_TRACK_ENTRY    r_entries [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             r_collision;

    EX_TRACK_ENTRY    w_next [DEPTH];
    logic [DEPTH-1:0] w_busy, w_ready, w_retire, w_claimed, w_next_busy;
    logic [N_WB-1:0]  w_sel_valid;
    logic [DEPTH-1:0] w_grant   [N_WB];
    logic [IDX_W-1:0] w_sel_idx [N_WB];
    logic [CNT_W-1:0] w_count_next;
    logic             w_coll_set;

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            w_busy[s]       = r_entries[s].pkt.valid;
            w_ready[s]      = w_busy[s] && (r_entries[s].cnt == '0);
            o_ex_entries[s] = r_entries[s].pkt;
        end
    end

    ex_wb_select #(.DEPTH(DEPTH), .N_WB(N_WB)) u_wb_select (
        .i_req   (w_ready),
        .o_valid (w_sel_valid),
        .o_grant (w_grant),
        .o_idx   (w_sel_idx)
    );

    // Presentation depends on registered state only, never on wb_ready.
    assign wb.wb_valid = w_sel_valid;
    always_comb begin
        for (int p = 0; p < N_WB; p++) begin
            wb.wb_packet[p] = r_entries[w_sel_idx[p]].pkt;
            wb.wb_idx[p]    = w_sel_idx[p];
        end
    end

    // Next-state: countdown and retire first, then issues overlay in port
    // order so a later port wins a shared slot and issue beats retire.
    always_comb begin
        w_retire   = '0;
        w_claimed  = '0;
        w_coll_set = 1'b0;
        for (int p = 0; p < N_WB; p++)
            w_retire = w_retire | (w_grant[p] & {DEPTH{w_sel_valid[p] & wb.wb_ready[p]}});
        for (int s = 0; s < DEPTH; s++) begin
            w_next[s] = r_entries[s];
            if (w_retire[s])
                w_next[s] = empty_entry();
            else if (w_busy[s] && r_entries[s].cnt != '0)
                w_next[s].cnt = r_entries[s].cnt - 1'b1;
        end
        for (int i = 0; i < N_ISSUE; i++) begin
            if (i_is_ex_packet[i].valid) begin
                if (w_claimed[i_is_ex_packet[i].rs_idx] ||
                    (w_busy[i_is_ex_packet[i].rs_idx] && !w_retire[i_is_ex_packet[i].rs_idx]))
                    w_coll_set = 1'b1;
                w_claimed[i_is_ex_packet[i].rs_idx]  = 1'b1;
                w_next[i_is_ex_packet[i].rs_idx].pkt = i_is_ex_packet[i];
                w_next[i_is_ex_packet[i].rs_idx].cnt = i_issue_lat[i];
            end
        end
        if (i_interrupt) begin
            w_coll_set = 1'b0;
            for (int s = 0; s < DEPTH; s++)
                w_next[s] = empty_entry();
        end
        for (int s = 0; s < DEPTH; s++)
            w_next_busy[s] = w_next[s].pkt.valid;
        w_count_next = CNT_W'($countones(w_next_busy));
    end

    // NOTE: the entry array is reset in full (not just the valid bits) because
    // every slot must read back as a clean NOP entry straight out of reset.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int s = 0; s < DEPTH; s++)
                r_entries[s] <= empty_entry();
            r_count     <= '0;
            r_collision <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            for (int s = 0; s < DEPTH; s++)
                r_entries[s] <= w_next[s];
            r_count     <= w_count_next;
            r_collision <= r_collision | w_coll_set;
        end
    end

    assign o_ex_busy   = w_busy;
    assign o_ex_count  = r_count;
    assign o_collision = r_collision;

`ifdef EX_TRACKER_PERF_EN
    logic [CNT_W-1:0] r_hiwater;
    logic [31:0]      r_stall_cycles;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_hiwater      <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_count_next > r_hiwater)
                r_hiwater <= w_count_next;
            if (|(w_sel_valid & ~wb.wb_ready) && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_ex_hiwater      = r_hiwater;
    assign o_wb_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_ex_tracker.sv
// ----------------------------------------------------------------------------
// tb_ex_tracker
//   Directed scenarios followed by randomized traffic, all compared against a
//   slot/timestamp reference model of the tracker.
// ----------------------------------------------------------------------------
module tb_ex_tracker;
    import ex_tracker_pkg::*;

    localparam int DEPTH = 8, N_ISSUE = 2, N_WB = 2, LAT_W = 4, CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             interrupt;
    IS_EX_PACKET      is_pkt    [N_ISSUE];
    logic [LAT_W-1:0] issue_lat [N_ISSUE];
    IS_EX_PACKET      ex_entries [DEPTH];
    logic [DEPTH-1:0] ex_busy;
    logic [CNT_W-1:0] ex_count;
    logic             collision;
`ifdef EX_TRACKER_PERF_EN
    logic [CNT_W-1:0] ex_hiwater;
    logic [31:0]      wb_stall_cycles;
`endif

    ex_tracker_if #(.DEPTH(DEPTH), .N_WB(N_WB)) wb_if ();

    ex_tracker #(.DEPTH(DEPTH), .N_ISSUE(N_ISSUE), .N_WB(N_WB), .LAT_W(LAT_W)) dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_interrupt    (interrupt),
        .i_is_ex_packet (is_pkt),
        .i_issue_lat    (issue_lat),
        .wb             (wb_if),
        .o_ex_entries   (ex_entries),
        .o_ex_busy      (ex_busy),
        .o_ex_count     (ex_count),
        .o_collision    (collision)
`ifdef EX_TRACKER_PERF_EN
        ,
        .o_ex_hiwater      (ex_hiwater),
        .o_wb_stall_cycles (wb_stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: a slot is ready once the edge count reaches its
    // issue edge plus the requested latency.
    IS_EX_PACKET m_pkt      [DEPTH];
    bit          m_busy     [DEPTH];
    int          m_ready_at [DEPTH];
    bit          m_coll;
    int          edge_no;
    bit          e_valid [N_WB];
    int          e_idx   [N_WB];
    int          m_hiwater;
    longint      m_stall;
    IS_EX_PACKET saved_pkt;
    int          total = 0, bad = 0;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic IS_EX_PACKET nop_pkt();
        IS_EX_PACKET p;
        p      = '0;
        p.inst = `NOP;
        return p;
    endfunction

    function automatic IS_EX_PACKET mk_pkt(int slot);
        IS_EX_PACKET p;
        p.inst   = $urandom;
        p.npc    = $urandom;
        p.rs_idx = RS_IDX_W'(slot);
        p.valid  = 1'b1;
        return p;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < DEPTH; s++) begin
            m_busy[s] = 1'b0;
            m_pkt[s]  = nop_pkt();
        end
        m_coll    = 1'b0;
        m_hiwater = 0;
        m_stall   = 0;
    endfunction

    function automatic void model_select();
        int q[$];
        for (int s = 0; s < DEPTH; s++)
            if (m_busy[s] && edge_no >= m_ready_at[s]) q.push_back(s);
        for (int p = 0; p < N_WB; p++) begin
            e_valid[p] = (q.size() > p);
            e_idx[p]   = (q.size() > p) ? q[p] : 0;
        end
    endfunction

    task automatic compare_all();
        logic [DEPTH-1:0] ev;
        int n = 0;
        model_select();
        for (int p = 0; p < N_WB; p++) begin
            check($sformatf("wb_valid%0d", p), 128'(wb_if.wb_valid[p]), 128'(e_valid[p]));
            if (e_valid[p]) begin
                check($sformatf("wb_idx%0d", p), 128'(wb_if.wb_idx[p]), 128'(e_idx[p]));
                check($sformatf("wb_pkt%0d", p), 128'(wb_if.wb_packet[p]), 128'(m_pkt[e_idx[p]]));
            end
        end
        for (int s = 0; s < DEPTH; s++) begin
            ev[s] = m_busy[s];
            n += int'(m_busy[s]);
            check($sformatf("entry%0d", s), 128'(ex_entries[s]),
                  128'(m_busy[s] ? m_pkt[s] : nop_pkt()));
        end
        check("ex_busy", 128'(ex_busy), 128'(ev));
        check("ex_count", 128'(ex_count), 128'(n));
        check("collision", 128'(collision), 128'(m_coll));
`ifdef EX_TRACKER_PERF_EN
        check("hiwater", 128'(ex_hiwater), 128'(m_hiwater));
        check("stall", 128'(wb_stall_cycles), 128'(m_stall));
`endif
    endtask

    task automatic idle();
        for (int i = 0; i < N_ISSUE; i++) begin
            is_pkt[i]    = '0;
            issue_lat[i] = '0;
        end
        interrupt = 1'b0;
    endtask

    task automatic issue(int port, int slot, int lat);
        is_pkt[port]    = mk_pkt(slot);
        issue_lat[port] = LAT_W'(lat);
    endtask

    // One clock: apply the driven inputs to the model, step the edge, compare.
    task automatic tick();
        bit retire [DEPTH];
        bit stalled = 1'b0;
        int n = 0;
        model_select();
        for (int s = 0; s < DEPTH; s++) retire[s] = 1'b0;
        for (int p = 0; p < N_WB; p++) begin
            if (e_valid[p] && wb_if.wb_ready[p]) retire[e_idx[p]] = 1'b1;
            if (e_valid[p] && !wb_if.wb_ready[p]) stalled = 1'b1;
        end
        if (stalled && m_stall < 64'hFFFF_FFFF) m_stall++;
        @(posedge clock);
        edge_no++;
        for (int s = 0; s < DEPTH; s++)
            if (interrupt || retire[s]) m_busy[s] = 1'b0;
        if (!interrupt) begin
            for (int i = 0; i < N_ISSUE; i++) begin
                if (is_pkt[i].valid) begin
                    int s = int'(is_pkt[i].rs_idx);
                    if (m_busy[s]) m_coll = 1'b1;
                    m_busy[s]     = 1'b1;
                    m_pkt[s]      = is_pkt[i];
                    m_ready_at[s] = edge_no + int'(issue_lat[i]);
                end
            end
        end
        for (int s = 0; s < DEPTH; s++) n += int'(m_busy[s]);
        if (n > m_hiwater) m_hiwater = n;
        #1;
        compare_all();
        idle();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 128'(ex_busy), 128'(0));
        check("rst_count", 128'(ex_count), 128'(0));
        check("rst_wb_valid", 128'(wb_if.wb_valid), 128'(0));
        model_reset();
        compare_all();
        #2 reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        wb_if.wb_ready = '0;
        idle();
        edge_no = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("init_count", 128'(ex_count), 128'(0));
        check("init_coll", 128'(collision), 128'(0));
        compare_all();
        #2 reset = 1'b1;

        // Latency: slot 5, lat 3.
        wb_if.wb_ready = 2'b11;
        issue(0, 5, 3); tick();
        repeat (3) tick();
        check("lat_valid", 128'(wb_if.wb_valid[0]), 128'(1));
        check("lat_idx", 128'(wb_if.wb_idx[0]), 128'(5));
        tick();
        check("lat_freed", 128'(ex_busy[5]), 128'(0));

        // Dual issue, zero latency, full drain.
        issue(0, 2, 0); issue(1, 7, 0); tick();
        check("multi_cnt2", 128'(ex_count), 128'(2));
        check("multi_p0", 128'(wb_if.wb_idx[0]), 128'(2));
        check("multi_p1", 128'(wb_if.wb_idx[1]), 128'(7));
        tick();
        check("multi_cnt0", 128'(ex_count), 128'(0));

        // Backpressure on port 1.
        wb_if.wb_ready = 2'b00;
        issue(0, 1, 0); issue(1, 3, 0); tick();
        issue(0, 4, 0); tick();
        check("bp_pre_p0", 128'(wb_if.wb_idx[0]), 128'(1));
        check("bp_pre_p1", 128'(wb_if.wb_idx[1]), 128'(3));
        wb_if.wb_ready = 2'b01; tick();
        check("bp_p0", 128'(wb_if.wb_idx[0]), 128'(3));
        check("bp_p1", 128'(wb_if.wb_idx[1]), 128'(4));
        wb_if.wb_ready = 2'b11; repeat (2) tick();

        // Issue into a slot that retires the same cycle.
        wb_if.wb_ready = 2'b00;
        issue(0, 6, 0); tick();
        wb_if.wb_ready = 2'b01;
        issue(0, 6, 2); saved_pkt = is_pkt[0]; tick();
        check("reissue_coll", 128'(collision), 128'(0));
        check("reissue_pkt", 128'(ex_entries[6]), 128'(saved_pkt));
        wb_if.wb_ready = 2'b11; repeat (3) tick();

        // Both ports to slot 6.
        issue(0, 6, 1); issue(1, 6, 1); saved_pkt = is_pkt[1]; tick();
        check("dual_coll", 128'(collision), 128'(1));
        check("dual_pkt", 128'(ex_entries[6]), 128'(saved_pkt));
        repeat (3) tick();

        // Interrupt with four busy slots and a concurrent issue.
        wb_if.wb_ready = 2'b00;
        issue(0, 0, 15); issue(1, 1, 15); tick();
        issue(0, 2, 15); issue(1, 3, 15); tick();
        check("irq_pre_cnt", 128'(ex_count), 128'(4));
        issue(0, 5, 0); interrupt = 1'b1; tick();
        check("irq_cnt", 128'(ex_count), 128'(0));
        check("irq_slot5", 128'(ex_entries[5].valid), 128'(0));
        check("irq_coll_kept", 128'(collision), 128'(1));

        // Reset mid-operation with three busy slots.
        issue(0, 0, 0); issue(1, 3, 15); tick();
        issue(0, 4, 15); tick();
        check("mrst_pre_cnt", 128'(ex_count), 128'(3));
        mid_reset();
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_ISSUE; i++) begin
                if ($urandom_range(0, 99) < 40)
                    issue(i, int'($urandom_range(0, DEPTH - 1)),
                          ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4)));
            end
            wb_if.wb_ready = 2'($urandom_range(0, 3));
            interrupt      = ($urandom_range(0, 99) < 2);
            tick();
            if (c % 700 == 699) mid_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
